tpu_job_scheduler: RTL and testbench

- Round-robin arbiter and sequencer that shares one tpu GEMM engine between NUM_REQ requesters.
- Each requester submits a job descriptor (m, k, n and base addresses for A, B and P) over a valid/ready handshake.
- The scheduler latches the winning descriptor, drives the tpu start/config inputs, waits for tpu completion, then returns a one-cycle done pulse to the owning requester.
- Sits between the host/DMA command layer and the tpu top.

---
 rtl/tpu_job_scheduler_pkg.sv | 27 ++
 rtl/tpu_job_scheduler_if.sv | 31 +++
 rtl/tpu_job_scheduler_rr_arbiter.sv | 25 ++
 rtl/tpu_job_scheduler.sv | 136 +++++++++++++
 tb/tb_tpu_job_scheduler.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_job_scheduler_pkg.sv
// Shared types and helpers for the tpu job scheduler and its round-robin arbiter.
// Optional performance counters are enabled by defining TPU_SCHED_PERF_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

package tpu_job_scheduler_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_ISSUE = 2'd1,
    SCHED_WAIT  = 2'd2,
    SCHED_DONE  = 2'd3
  } sched_state_e;

  localparam int PERF_WIDTH = 32;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [PERF_WIDTH-1:0] sat_inc(input logic [PERF_WIDTH-1:0] v);
    return (&v) ? v : v + PERF_WIDTH'(1);
  endfunction

endpackage

// File: rtl/tpu_job_scheduler_if.sv
// Requester-side and tpu-side signal bundle of the tpu job scheduler.
interface tpu_job_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int AW      = `ADDR_WIDTH
);
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic [NUM_REQ*AW-1:0] req_m_i, req_k_i, req_n_i;
  logic [NUM_REQ*AW-1:0] req_base_a_i, req_base_b_i, req_base_p_i;
  logic [NUM_REQ-1:0]    done_o;
  logic [NUM_REQ-1:0]    err_o;
  logic                  busy_o;
  logic                  tpu_start_o;
  logic                  tpu_valid_i;
  logic [AW-1:0]         tpu_m_o, tpu_k_o, tpu_n_o;
  logic [AW-1:0]         tpu_base_a_o, tpu_base_b_o, tpu_base_p_o;

  modport slave (
    input  req_valid_i, req_m_i, req_k_i, req_n_i,
           req_base_a_i, req_base_b_i, req_base_p_i, tpu_valid_i,
    output req_ready_o, done_o, err_o, busy_o, tpu_start_o,
           tpu_m_o, tpu_k_o, tpu_n_o, tpu_base_a_o, tpu_base_b_o, tpu_base_p_o
  );

  modport master (
    output req_valid_i, req_m_i, req_k_i, req_n_i,
           req_base_a_i, req_base_b_i, req_base_p_i, tpu_valid_i,
    input  req_ready_o, done_o, err_o, busy_o, tpu_start_o,
           tpu_m_o, tpu_k_o, tpu_n_o, tpu_base_a_o, tpu_base_b_o, tpu_base_p_o
  );
endinterface

// File: rtl/tpu_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);
  // Walk offsets from farthest to nearest so the closest request overrides.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (req_i[r] && (r == (int'(ptr_i) + off) % NUM_REQ)) begin
          grant_o    = '0;
          grant_o[r] = 1'b1;
          idx_o      = IDX_W'(r);
        end
      end
    end
  end
endmodule

// File: rtl/tpu_job_scheduler.sv
// Shares one tpu GEMM engine between NUM_REQ requesters with round-robin job acceptance.
// Defining TPU_SCHED_PERF_EN adds saturating job/busy-cycle performance counters.
module tpu_job_scheduler
  import tpu_job_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int AW      = `ADDR_WIDTH,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
`ifdef TPU_SCHED_PERF_EN
  output logic [PERF_WIDTH-1:0] perf_jobs_o,
  output logic [PERF_WIDTH-1:0] perf_busy_cyc_o,
  output logic [PERF_WIDTH-1:0] perf_last_cyc_o,
`endif
  tpu_job_scheduler_if.slave    bus
);

  sched_state_e          state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic                  err_q, err_d;
  logic [5:0][AW-1:0]    desc_q, desc_d;
  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      winner;
  logic [5:0][AW-1:0]    req_desc [NUM_REQ];

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req_i   (bus.req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (winner)
  );

  // Descriptor slots: 0=m 1=k 2=n 3=base_a 4=base_b 5=base_p.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_desc
      assign req_desc[gi] = {bus.req_base_p_i[gi*AW +: AW], bus.req_base_b_i[gi*AW +: AW],
                             bus.req_base_a_i[gi*AW +: AW], bus.req_n_i[gi*AW +: AW],
                             bus.req_k_i[gi*AW +: AW],      bus.req_m_i[gi*AW +: AW]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    err_d   = err_q;
    desc_d  = desc_q;
    unique case (state_q)
      SCHED_IDLE: begin
        if (|bus.req_valid_i) begin
          owner_d = winner;
          desc_d  = req_desc[winner];
          ptr_d   = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
          err_d   = (req_desc[winner][0] == '0) || (req_desc[winner][1] == '0) ||
                    (req_desc[winner][2] == '0);
          state_d = err_d ? SCHED_DONE : SCHED_ISSUE;
        end
      end
      SCHED_ISSUE: state_d = SCHED_WAIT;
      SCHED_WAIT:  if (bus.tpu_valid_i) state_d = SCHED_DONE;
      SCHED_DONE:  state_d = SCHED_IDLE;
      default:     state_d = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SCHED_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      err_q   <= 1'b0;
      desc_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      err_q   <= err_d;
      desc_q  <= desc_d;
    end
  end

  // Ready is forced low during reset so every output reads 0 while rst_ni is held.
  assign bus.req_ready_o  = (state_q == SCHED_IDLE && rst_ni) ? grant : '0;
  assign bus.busy_o       = (state_q != SCHED_IDLE);
  assign bus.tpu_start_o  = (state_q == SCHED_ISSUE);
  assign bus.done_o       = (state_q == SCHED_DONE) ? (NUM_REQ'(1) << owner_q) : '0;
  assign bus.err_o        = (state_q == SCHED_DONE && err_q) ? (NUM_REQ'(1) << owner_q) : '0;
  assign bus.tpu_m_o      = desc_q[0];
  assign bus.tpu_k_o      = desc_q[1];
  assign bus.tpu_n_o      = desc_q[2];
  assign bus.tpu_base_a_o = desc_q[3];
  assign bus.tpu_base_b_o = desc_q[4];
  assign bus.tpu_base_p_o = desc_q[5];

`ifdef TPU_SCHED_PERF_EN
  logic [PERF_WIDTH-1:0] jobs_q, jobs_d, busy_cyc_q, busy_cyc_d;
  logic [PERF_WIDTH-1:0] last_q, last_d, cur_q, cur_d;

  // cur counts WAIT cycles of the job in flight; a rejected job reports 0.
  always_comb begin
    jobs_d     = jobs_q;
    busy_cyc_d = busy_cyc_q;
    last_d     = last_q;
    cur_d      = cur_q;
    if (state_q == SCHED_IDLE)  cur_d = '0;
    if (state_q == SCHED_ISSUE) jobs_d = sat_inc(jobs_q);
    if (state_q == SCHED_WAIT) begin
      busy_cyc_d = sat_inc(busy_cyc_q);
      cur_d      = sat_inc(cur_q);
    end
    if (state_q == SCHED_DONE)  last_d = cur_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      jobs_q     <= '0;
      busy_cyc_q <= '0;
      last_q     <= '0;
      cur_q      <= '0;
    end else begin
      jobs_q     <= jobs_d;
      busy_cyc_q <= busy_cyc_d;
      last_q     <= last_d;
      cur_q      <= cur_d;
    end
  end

  assign perf_jobs_o     = jobs_q;
  assign perf_busy_cyc_o = busy_cyc_q;
  assign perf_last_cyc_o = last_q;
`endif

endmodule

// File: tb/tb_tpu_job_scheduler.sv
// Directed and randomized checks of tpu_job_scheduler against a job-level reference model.
`timescale 1ns/1ps
module tb_tpu_job_scheduler;
  localparam int NUM_REQ = 3;
  localparam int AW      = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tpu_job_scheduler_if #(.NUM_REQ(NUM_REQ), .AW(AW)) bus ();

`ifdef TPU_SCHED_PERF_EN
  logic [31:0] perf_jobs, perf_busy, perf_last;
`endif

  tpu_job_scheduler #(.NUM_REQ(NUM_REQ), .AW(AW)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
`ifdef TPU_SCHED_PERF_EN
    .perf_jobs_o     (perf_jobs),
    .perf_busy_cyc_o (perf_busy),
    .perf_last_cyc_o (perf_last),
`endif
    .bus             (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: round-robin pointer, per-requester descriptors, perf totals.
  int          ptr = 0;
  logic [AW-1:0] dm[NUM_REQ], dk[NUM_REQ], dn[NUM_REQ], da[NUM_REQ], db[NUM_REQ], dp[NUM_REQ];
  int unsigned m_jobs = 0, m_busy = 0, m_last = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rnd_dim(input int zero_pct);
    if ($urandom_range(0, 99) < zero_pct) return '0;
    return AW'($urandom_range(1, 65535));
  endfunction

  task automatic rand_desc(input int zero_pct);
    for (int r = 0; r < NUM_REQ; r++) begin
      dm[r] = rnd_dim(zero_pct);
      dk[r] = rnd_dim(zero_pct);
      dn[r] = rnd_dim(zero_pct);
      da[r] = AW'($urandom);
      db[r] = AW'($urandom);
      dp[r] = AW'($urandom);
    end
  endtask

  task automatic drive_desc();
    for (int r = 0; r < NUM_REQ; r++) begin
      bus.req_m_i[r*AW +: AW]      = dm[r];
      bus.req_k_i[r*AW +: AW]      = dk[r];
      bus.req_n_i[r*AW +: AW]      = dn[r];
      bus.req_base_a_i[r*AW +: AW] = da[r];
      bus.req_base_b_i[r*AW +: AW] = db[r];
      bus.req_base_p_i[r*AW +: AW] = dp[r];
    end
  endtask

  function automatic int model_winner(input logic [NUM_REQ-1:0] mask);
    for (int off = 0; off < NUM_REQ; off++)
      if (mask[(ptr + off) % NUM_REQ]) return (ptr + off) % NUM_REQ;
    return -1;
  endfunction

  task automatic check_perf();
`ifdef TPU_SCHED_PERF_EN
    check("perf_jobs", perf_jobs, m_jobs);
    check("perf_busy", perf_busy, m_busy);
    check("perf_last", perf_last, m_last);
`endif
  endtask

  // One complete job from the IDLE cycle where mask is presented; l_wait idle WAIT cycles precede tpu_valid.
  task automatic run_job(input logic [NUM_REQ-1:0] mask, input int l_wait,
                         input bit spurious, input bit scramble);
    int w;
    logic [AW-1:0] sm, sk, sn, sa, sb, sp;
    bus.req_valid_i = mask;
    drive_desc();
    #1;
    w = model_winner(mask);
    check("ready_grant", bus.req_ready_o, 64'(1 << w));
    sm = dm[w]; sk = dk[w]; sn = dn[w]; sa = da[w]; sb = db[w]; sp = dp[w];
    ptr = (w + 1) % NUM_REQ;
    tick();
    check("busy_after_accept", bus.busy_o, 1);
    check("ready_low_busy", bus.req_ready_o, 0);
    if (sm == '0 || sk == '0 || sn == '0) begin
      check("rej_done", bus.done_o, 64'(1 << w));
      check("rej_err", bus.err_o, 64'(1 << w));
      check("rej_no_start", bus.tpu_start_o, 0);
      m_last = 0;
      tick();
      check("rej_idle", bus.busy_o, 0);
      check("rej_no_start2", bus.tpu_start_o, 0);
    end else begin
      check("start", bus.tpu_start_o, 1);
      check("cfg", {bus.tpu_m_o, bus.tpu_k_o, bus.tpu_n_o, bus.tpu_base_a_o},
            {sm, sk, sn, sa});
      check("cfg_bp", {bus.tpu_base_b_o, bus.tpu_base_p_o}, {sb, sp});
      m_jobs++;
      if (spurious) bus.tpu_valid_i = 1'b1;
      if (scramble) begin
        rand_desc(20);
        drive_desc();
      end
      tick();
      check("start_one_cycle", bus.tpu_start_o, 0);
      check("no_done_issue", bus.done_o, 0);
      bus.tpu_valid_i = 1'b0;
      repeat (l_wait) begin
        tick();
        if (scramble) bus.req_valid_i = NUM_REQ'($urandom);
        #1;
        check("wait_no_done", bus.done_o, 0);
        check("wait_ready_low", bus.req_ready_o, 0);
      end
      bus.tpu_valid_i = 1'b1;
      tick();
      bus.tpu_valid_i = 1'b0;
      m_busy += l_wait + 1;
      m_last  = l_wait + 1;
      check("done", bus.done_o, 64'(1 << w));
      check("done_err", bus.err_o, 0);
      check("done_ready_low", bus.req_ready_o, 0);
      check("cfg_held", {bus.tpu_m_o, bus.tpu_k_o, bus.tpu_n_o, bus.tpu_base_p_o},
            {sm, sk, sn, sp});
      tick();
      check("done_pulse_end", bus.done_o, 0);
      check("idle_busy", bus.busy_o, 0);
    end
    check_perf();
    $display("[TB] job mask=%b winner=%0d m=%0d k=%0d n=%0d wait=%0d", mask, w, sm, sk, sn, l_wait);
    bus.req_valid_i = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid_i = '0;
    bus.tpu_valid_i = 1'b0;
    rand_desc(0);
    drive_desc();
    #1;
    check("rst_busy", bus.busy_o, 0);
    check("rst_start", bus.tpu_start_o, 0);
    check("rst_done_err", {bus.done_o, bus.err_o}, 0);
    check("rst_cfg", {bus.tpu_m_o, bus.tpu_k_o, bus.tpu_n_o, bus.tpu_base_a_o}, 0);
    check_perf();
    #11 rst_n = 1'b1;
    tick();

    // Single job from requester 0 with tpu completion after 20 WAIT cycles.
    dm[0] = 8; dk[0] = 4; dn[0] = 8; da[0] = 'h000; db[0] = 'h100; dp[0] = 'h200;
    run_job(3'b001, 19, 1'b0, 1'b0);

    // Rejected job: requester 1 with k=0.
    dm[1] = 5; dk[1] = 0; dn[1] = 7;
    run_job(3'b010, 0, 1'b0, 1'b0);

    // Spurious tpu_valid while idle is ignored.
    bus.tpu_valid_i = 1'b1;
    tick();
    check("spur_idle_done", bus.done_o, 0);
    check("spur_idle_busy", bus.busy_o, 0);
    bus.tpu_valid_i = 1'b0;

    // Continuous contention, plus spurious valid during ISSUE.
    rand_desc(0);
    for (int j = 0; j < 4; j++) run_job('1, 2, 1'b1, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 40; j++) begin
      rand_desc(12);
      run_job(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)), $urandom_range(0, 6),
              1'($urandom), 1'($urandom));
    end

    // Reset in the middle of WAIT.
    rand_desc(0);
    drive_desc();
    bus.req_valid_i = 3'b001;
    ptr = (model_winner(3'b001) + 1) % NUM_REQ;
    tick();
    bus.req_valid_i = '0;
    tick();
    tick();
    rst_n = 1'b0;
    bus.req_valid_i = '1;
    #1;
    check("rstw_busy", bus.busy_o, 0);
    check("rstw_done", bus.done_o, 0);
    check("rstw_ready", bus.req_ready_o, 0);
    check("rstw_cfg", {bus.tpu_m_o, bus.tpu_base_p_o}, 0);
    ptr = 0; m_jobs = 0; m_busy = 0; m_last = 0;
    check_perf();
    tick();
    tick();
    #2 rst_n = 1'b1;
    run_job('1, 1, 1'b0, 1'b0);

    // Three jobs with 10, 15 and 7 WAIT cycles after a fresh reset.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    ptr = 0; m_jobs = 0; m_busy = 0; m_last = 0;
    tick();
    rand_desc(0);
    run_job(3'b100, 9, 1'b0, 1'b0);
    run_job(3'b010, 14, 1'b0, 1'b0);
    run_job(3'b001, 6, 1'b0, 1'b0);
`ifdef TPU_SCHED_PERF_EN
    check("perf3_jobs", perf_jobs, 3);
    check("perf3_busy", perf_busy, 32);
    check("perf3_last", perf_last, 7);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
